mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports, the memory port and the busy flag of mem_arbiter.
// The slave modport is the arbiter's view. The master modport is the environment's view:
// the requesters plus the memory.
interface mem_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [12:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_done;
    logic [15:0] cpu_rdata;

    logic        dma_req;
    logic        dma_we;
    logic [12:0] dma_addr;
    logic [15:0] dma_wdata;
    logic        dma_gnt;
    logic        dma_done;
    logic [15:0] dma_rdata;

    logic [12:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [15:0] mem_rdata;

    logic        busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_done, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_done, dma_rdata,
        output mem_addr, mem_wdata, mem_re, mem_we,
        input  mem_rdata,
        output busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_done, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_done, dma_rdata,
        input  mem_addr, mem_wdata, mem_re, mem_we,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (CPU, DMA) round-robin arbiter in front of a single-port memory with a
// fixed read latency. One access is in flight at a time: IDLE -> ISSUE -> WAIT -> DONE.
// All outputs are registered.
module mem_arbiter #(
    parameter int unsigned RD_LAT = 2  // mem_re cycle to mem_rdata valid, 1..7
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    localparam logic [2:0] RdLat = 3'(RD_LAT);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e      state_q;
    logic [2:0]  cnt_q;
    logic        last_dma_q;  // 1 = DMA was granted last
    logic        win_dma_q;   // requester owning the access in flight
    logic        we_q;
    logic        cpu_gnt_q, cpu_done_q, dma_gnt_q, dma_done_q;
    logic        mem_re_q, mem_we_q, busy_q;
    logic [12:0] mem_addr_q;
    logic [15:0] mem_wdata_q;
    logic [15:0] cpu_rdata_q, dma_rdata_q;

    logic        win_dma;
    logic        win_we;
    logic [12:0] win_addr;
    logic [15:0] win_wdata;

    // Round-robin pick: a lone requester wins, on a tie the one not granted last wins.
    always_comb begin
        win_dma   = bus.dma_req && (!bus.cpu_req || !last_dma_q);
        win_we    = win_dma ? bus.dma_we    : bus.cpu_we;
        win_addr  = win_dma ? bus.dma_addr  : bus.cpu_addr;
        win_wdata = win_dma ? bus.dma_wdata : bus.cpu_wdata;
    end

    // Access sequencer; the outputs for the next state are registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= 3'd0;
            last_dma_q  <= 1'b1;
            win_dma_q   <= 1'b0;
            we_q        <= 1'b0;
            cpu_gnt_q   <= 1'b0;
            cpu_done_q  <= 1'b0;
            dma_gnt_q   <= 1'b0;
            dma_done_q  <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            mem_addr_q  <= 13'd0;
            mem_wdata_q <= 16'd0;
            cpu_rdata_q <= 16'd0;
            dma_rdata_q <= 16'd0;
        end else begin
            // Pulses and strobes last one cycle unless re-armed below.
            cpu_gnt_q  <= 1'b0;
            dma_gnt_q  <= 1'b0;
            cpu_done_q <= 1'b0;
            dma_done_q <= 1'b0;
            mem_re_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.cpu_req || bus.dma_req) begin
                        win_dma_q   <= win_dma;
                        last_dma_q  <= win_dma;
                        we_q        <= win_we;
                        mem_addr_q  <= win_addr;
                        mem_wdata_q <= win_wdata;
                        // Armed here so they are visible during the ISSUE cycle.
                        mem_re_q    <= !win_we;
                        mem_we_q    <= win_we;
                        cpu_gnt_q   <= !win_dma;
                        dma_gnt_q   <= win_dma;
                        busy_q      <= 1'b1;
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
                    cnt_q   <= RdLat;
                    state_q <= StWait;
                end
                StWait: begin
                    cnt_q <= cnt_q - 3'd1;
                    // Count of 1 is the cycle the memory presents read data.
                    if (cnt_q == 3'd1) begin
                        if (!we_q) begin
                            if (win_dma_q) begin
                                dma_rdata_q <= bus.mem_rdata;
                            end else begin
                                cpu_rdata_q <= bus.mem_rdata;
                            end
                        end
                        cpu_done_q <= !win_dma_q;
                        dma_done_q <= win_dma_q;
                        state_q    <= StDone;
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.cpu_gnt   = cpu_gnt_q;
    assign bus.cpu_done  = cpu_done_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dma_gnt   = dma_gnt_q;
    assign bus.dma_done  = dma_done_q;
    assign bus.dma_rdata = dma_rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.busy      = busy_q;

endmodule
